// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the CP0 system-control block.
//   Register numbers, SR/Cause field positions, exception codes and the
//   NORMAL/HANDLER state encoding used by cp0_unit.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR field positions
    localparam int SR_IM_HI  = 15;
    localparam int SR_IM_LO  = 10;
    localparam int SR_EXL    = 1;
    localparam int SR_IE     = 0;

    // Cause field positions
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // The state is exactly SR.EXL
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

    // Address the EPC should record for the faulting/interrupted instruction:
    // a delay-slot instruction restarts at its branch.
    function automatic logic [31:0] epc_target(input logic [31:0] pc_i, input logic bd_i);
        return bd_i ? (pc_i - 32'd4) : pc_i;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 register block (SR, Cause, EPC, PRId) with exception and
// interrupt request generation and handler-entry/eret sequencing.
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   reset     - synchronous active-high reset
//   addr      - CP0 register number for mfc0/mtc0
//   we        - mtc0 write enable
//   din       - mtc0 write data
//   dout      - mfc0 read data (combinational, pre-edge contents)
//   pc        - PC of the instruction at the commit point
//   bd        - commit-point instruction sits in a branch delay slot
//   exc_code  - synchronous exception code, 0 = none
//   hw_int    - device interrupt lines
//   eret      - eret at the commit point
//   req       - enter the handler this cycle (combinational)
//   epc_out   - current EPC register value
//
// state       | meaning
// ------------+---------------------------------------------------
// ST_NORMAL   | EXL=0, exceptions and enabled interrupts accepted
// ST_HANDLER  | EXL=1, inside handler, req held low until eret
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_2019
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    cp0_state_e  state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        exl;
    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign exl     = (state_q == ST_HANDLER);
    // Live hw_int is used, so a line rising this cycle is taken immediately.
    assign int_req = ie_q & ~exl & (|(hw_int & im_q));
    assign exc_req = ~exl & (exc_code != 5'd0);
    assign req     = int_req | exc_req;
    assign epc_out = epc_q;

    always_comb begin
        sr_val                     = '0;
        sr_val[SR_IM_HI:SR_IM_LO]  = im_q;
        sr_val[SR_EXL]             = exl;
        sr_val[SR_IE]              = ie_q;

        cause_val                          = '0;
        cause_val[CAUSE_BD]                = bd_q;
        cause_val[CAUSE_IP_HI:CAUSE_IP_LO] = ip_q;
        cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
    end

    always_comb begin
        case (addr)
            CP0_SR:    dout = sr_val;
            CP0_CAUSE: dout = cause_val;
            CP0_EPC:   dout = epc_q;
            CP0_PRID:  dout = PRID;
            default:   dout = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        im_d    = im_q;
        ie_d    = ie_q;
        bd_d    = bd_q;
        ip_d    = hw_int;
        exc_d   = exc_q;
        epc_d   = epc_q;

        if (req) begin
            // Handler entry; any mtc0 in the same cycle is dropped.
            state_d = ST_HANDLER;
            bd_d    = bd;
            exc_d   = int_req ? EXC_INT : exc_code;
            epc_d   = epc_target(pc, bd);
        end else begin
            if (we) begin
                case (addr)
                    CP0_SR: begin
                        im_d    = din[SR_IM_HI:SR_IM_LO];
                        ie_d    = din[SR_IE];
                        state_d = din[SR_EXL] ? ST_HANDLER : ST_NORMAL;
                    end
                    CP0_EPC: epc_d = din;
                    default: ;
                endcase
            end
            // eret's EXL clear takes precedence over a written EXL bit
            if (eret) begin
                state_d = ST_NORMAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NORMAL;
            im_q    <= '0;
            ie_q    <= 1'b0;
            bd_q    <= 1'b0;
            ip_q    <= '0;
            exc_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            ie_q    <= ie_d;
            bd_q    <= bd_d;
            ip_q    <= ip_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int n_chk  = 0;
    int n_pass = 0;

    cp0_unit #(.PRID(32'h0000_2019)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .we       (we),
        .din      (din),
        .dout     (dout),
        .pc       (pc),
        .bd       (bd),
        .exc_code (exc_code),
        .hw_int   (hw_int),
        .eret     (eret),
        .req      (req),
        .epc_out  (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Read a register through dout, leaving addr pointed at it.
    task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    // Advance one clock; inputs are driven 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; eret = 1'b0; exc_code = 5'd0; bd = 1'b0; din = '0;
    endtask

    initial begin
        reset = 1'b1; addr = 5'd0; we = 1'b0; din = '0; pc = '0; bd = 1'b0;
        exc_code = 5'd0; hw_int = '0; eret = 1'b0;

        // Reset also overrides a concurrent write and eret
        tick();
        addr = 5'd12; we = 1'b1; din = 32'hFFFF_FFFF; eret = 1'b1; hw_int = 6'h3F;
        tick();
        reset = 1'b0; idle(); hw_int = '0;
        chk_rd("rst_sr", 5'd12, 32'h0);
        chk_rd("rst_cause", 5'd13, 32'h0);
        chk_rd("rst_epc", 5'd14, 32'h0);
        chk("rst_epc_out", {31'd0, 1'b0} | epc_out, 32'h0);
        chk("rst_req", {31'd0, req}, 32'h0);
        chk_rd("prid", 5'd15, 32'h0000_2019);
        chk_rd("unmapped", 5'd3, 32'h0);

        // Interrupt entry; dout shows pre-edge SR during the write
        addr = 5'd12; we = 1'b1; din = 32'h0000_0401;
        #1;
        chk("no_bypass", dout, 32'h0);
        tick();
        idle();
        chk_rd("sr_written", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc = 32'h0000_3010;
        #1;
        chk("int_req", {31'd0, req}, 32'h1);
        tick();
        chk("int_req_after", {31'd0, req}, 32'h0);
        chk("int_epc_out", epc_out, 32'h0000_3010);
        chk_rd("int_sr", 5'd12, 32'h0000_0403);
        chk_rd("int_cause", 5'd13, 32'h0000_0400);

        // Return with an enabled interrupt still pending
        eret = 1'b1;
        #1;
        chk("eret_req_in_handler", {31'd0, req}, 32'h0);
        tick();
        idle();
        chk_rd("eret_sr", 5'd12, 32'h0000_0401);
        chk("pending_int_req", {31'd0, req}, 32'h1);
        pc = 32'h0000_3040;
        tick();
        chk("reentry_epc", epc_out, 32'h0000_3040);
        hw_int = '0; eret = 1'b1;
        tick();
        idle();

        // Delay-slot overflow exception; hw_int bit2 is masked
        hw_int = 6'b000100; exc_code = 5'd12; bd = 1'b1; pc = 32'h0000_3024;
        #1;
        chk("ov_req", {31'd0, req}, 32'h1);
        tick();
        idle();
        chk("ov_epc", epc_out, 32'h0000_3020);
        chk_rd("ov_cause", 5'd13, 32'h8000_1030);

        // eret and mtc0 SR together: eret clears EXL, IM/IE take din
        addr = 5'd12; we = 1'b1; din = 32'h0000_0403; eret = 1'b1; hw_int = '0;
        tick();
        idle();
        chk_rd("eret_vs_mtc0", 5'd12, 32'h0000_0401);

        // mtc0 cannot change Cause
        addr = 5'd13; we = 1'b1; din = 32'hFFFF_FFFF;
        tick();
        idle();
        chk_rd("cause_ro", 5'd13, 32'h8000_0030);

        // Interrupt beats RI; same-cycle mtc0 EPC is discarded
        hw_int = 6'b000001; exc_code = 5'd10; pc = 32'h0000_3100;
        addr = 5'd14; we = 1'b1; din = 32'h0000_1234;
        #1;
        chk("prio_req", {31'd0, req}, 32'h1);
        tick();
        idle();
        chk("prio_epc", epc_out, 32'h0000_3100);
        chk_rd("prio_cause", 5'd13, 32'h0000_0400);
        hw_int = '0; eret = 1'b1;
        tick();
        idle();

        // Masking: IE=1, IM=0
        addr = 5'd12; we = 1'b1; din = 32'h0000_0001;
        tick();
        idle();
        hw_int = 6'b111111;
        #1;
        chk("mask_req", {31'd0, req}, 32'h0);
        tick();
        chk_rd("mask_cause", 5'd13, 32'h0000_FC00);
        hw_int = '0;

        // Full EPC write and misaligned exception pc
        addr = 5'd14; we = 1'b1; din = 32'hDEAD_BEEF;
        tick();
        idle();
        chk_rd("epc_write", 5'd14, 32'hDEAD_BEEF);
        exc_code = 5'd4; pc = 32'h0000_3013;
        tick();
        idle();
        chk("misaligned_epc", epc_out, 32'h0000_3013);
        chk_rd("adel_cause", 5'd13, 32'h0000_0010);
        eret = 1'b1;
        tick();
        idle();

        // mtc0 setting EXL enters the handler; unused SR bits read 0
        addr = 5'd12; we = 1'b1; din = 32'hFFFF_FFFF;
        tick();
        idle();
        chk_rd("sr_mask", 5'd12, 32'h0000_FC03);
        exc_code = 5'd5; hw_int = 6'h3F;
        #1;
        chk("mtc0_exl_blocks", {31'd0, req}, 32'h0);
        idle(); hw_int = '0; eret = 1'b1;
        tick();
        idle();

        // Reset in the middle of a handler
        addr = 5'd12; we = 1'b1; din = 32'h0000_0401;
        tick();
        idle();
        hw_int = 6'b000001; pc = 32'h0000_3010;
        tick();
        chk("pre_rst_epc", epc_out, 32'h0000_3010);
        reset = 1'b1; addr = 5'd12; we = 1'b1; din = 32'h0000_0403; eret = 1'b1;
        tick();
        reset = 1'b0; idle(); hw_int = '0;
        chk_rd("mid_rst_sr", 5'd12, 32'h0);
        chk_rd("mid_rst_cause", 5'd13, 32'h0);
        chk_rd("mid_rst_epc", 5'd14, 32'h0);
        chk("mid_rst_epc_out", epc_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
